mem_16x32_array: RTL and testbench
==================================

Name: mem_16x32_array

Overview:
- Single-port synchronous RAM: 16 words × 32 bits, with separate write and read enables.
- Sits behind the agent_1_intf interface (clk, rst, d_in, addr, en_wr, en_rd, d_out).
- It is the storage block exercised by the memory-agent environment.
- Write and read-data paths are both registered.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 16, number of words.
- ADDR_W, 4, address width; must equal $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- d_in  input  DATA_W  write data.
- addr  input  ADDR_W  shared read/write word address.
- en_wr  input  1  write enable, active-high.
- en_rd  input  1  read enable, active-high.
- d_out  output  DATA_W  registered read data.

Behaviour:
- Reset (rst=0, asynchronous assertion): all DEPTH words clear to 0; d_out clears to 0.
  - Both hold while rst=0, regardless of clk or enables.
  - Deassertion is synchronised to clk by the integrating design; the first active edge after rst=1 obeys the normal rules.
- Write: on a rising clk edge with rst=1 and en_wr=1, mem[addr] <= d_in. Takes effect on that edge.
- Read: on a rising clk edge with rst=1 and en_rd=1, d_out <= mem[addr].
  - Latency is one cycle: data is visible after the edge at which en_rd was sampled.
- en_rd=0: d_out holds its last value. No tri-state, no X.
- en_wr=0: memory unchanged.
- Simultaneous en_wr=1 and en_rd=1, same addr: read-before-write.
  - d_out gets the OLD contents.
  - The new data is written in the same edge and is readable from the next read.
- Simultaneous enables: only one addr port, so both operations always target the same word.
- Both enables 0: no state change.
- Address range:
  - All 2^ADDR_W addresses are valid; no wrap or out-of-range case at default parameters.
  - If DEPTH < 2^ADDR_W, writes to addr >= DEPTH are ignored, and reads from those addresses return 0.
- Reset mid-operation: any write or read in flight at reset assertion is discarded. Memory and d_out go to 0 immediately.
- X-handling: an enable at X under simulation must not silently corrupt memory. Add an assertion that flags X on en_wr, en_rd, or addr (when an enable is 1) while rst=1.
- No combinational path from any input to d_out.

Decomposition:
- Package mem_pkg:
  - localparams DATA_W=32, DEPTH=16, ADDR_W=4.
  - typedef word_t (logic [DATA_W-1:0]).
  - typedef addr_t (logic [ADDR_W-1:0]).
- Module mem_16x32_array holds:
  - the storage array (word_t mem [DEPTH]);
  - the write process (always_ff with async reset clearing all words);
  - the d_out register;
  - the assertion block.
- No sub-module needed. The storage array plus one output register is a single cohesive block.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release; read addr 0..15 with en_rd=1 → d_out=32'h0 one cycle after each read.
- Write/readback: write d_in=32'hDEAD_BEEF to addr 4'h3, then en_rd at addr 4'h3 next cycle → d_out=32'hDEADBEEF one cycle later.
  - Fill all 16 addresses with data = {28'h0, addr} ^ 32'hA5A5A5A5 and read back the same values.
- Read-before-write: preload addr 4'h7 = 32'h1111_1111; in one cycle drive en_wr=1, en_rd=1, addr=7, d_in=32'h2222_2222.
  - Required: d_out=32'h11111111.
  - Next read of addr 7 → 32'h22222222.
- Hold: after a read producing 32'h1234_5678, deassert en_rd for 5 cycles while changing addr and writing other words → d_out stays 32'h12345678.
- Async reset mid-operation: with memory filled and d_out=32'hFFFF_FFFF, assert rst=0 between clock edges.
  - d_out must go to 0 before the next clk edge.
  - After release, every address reads back 0.
- Write-disable: drive en_wr=0 with d_in=32'hCAFE_F00D at addr 4'hF → subsequent read of addr 15 returns the previous contents unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared sizing and types for the 16x32 single-port RAM.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mem_16x32_array.sv
// Single-port synchronous RAM, 16 x 32, registered write and read paths,
// read-before-write when both enables hit the same edge.
module mem_16x32_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en_wr,
  input  logic              en_rd,
  output logic [DATA_W-1:0] d_out
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  word_t dout_q;
  word_t dout_d;
  logic  addr_ok_s;
  word_t rd_word_s;

  // Words above DEPTH only exist when the address space is partially populated.
  if (DEPTH < (2 ** ADDR_W)) begin : g_partial
    assign addr_ok_s = (32'(addr) < DEPTH);
  end else begin : g_full
    assign addr_ok_s = 1'b1;
  end

  assign rd_word_s = addr_ok_s ? mem_q[addr] : {DATA_W{1'b0}};

  // Next-state for storage: write lands on the addressed word only.
  always_comb begin
    mem_d = mem_q;
    if (en_wr && addr_ok_s) begin
      mem_d[addr] = d_in;
    end else begin
      mem_d = mem_q;
    end
  end

  // Next-state for read data: samples the pre-write contents, otherwise holds.
  always_comb begin
    dout_d = dout_q;
    if (en_rd) begin
      dout_d = rd_word_s;
    end else begin
      dout_d = dout_q;
    end
  end

  // Storage and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      dout_q <= {DATA_W{1'b0}};
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign d_out = dout_q;

  // Unknown control must never reach the array unnoticed.
  a_ctrl_known : assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(en_wr) && !$isunknown(en_rd) &&
    ((en_wr || en_rd) -> !$isunknown(addr)))
    else $error("unknown enable or address on mem_16x32_array");

endmodule

// File: tb/tb_mem_16x32_array.sv
// Directed bench for mem_16x32_array: reset, write/readback, read-before-write,
// hold, asynchronous reset mid-operation and write-disable.
module tb_mem_16x32_array;

  logic        clk;
  logic        rst;
  logic [31:0] d_in;
  logic [3:0]  addr;
  logic        en_wr;
  logic        en_rd;
  logic [31:0] d_out;

  int n_checks;
  int n_fail;

  mem_16x32_array dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .addr  (addr),
    .en_wr (en_wr),
    .en_rd (en_rd),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; d_in = d; en_wr = 1'b1; en_rd = 1'b0;
    tick();
    en_wr = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    addr = a; en_rd = 1'b1; en_wr = 1'b0;
    tick();
    en_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_wr = 1'b0; en_rd = 1'b0; addr = 4'h0; d_in = 32'h0;
    repeat (3) tick();
    n_checks++;
    if (d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected %h", d_out, 32'h0);
    end
    rst = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      n_checks++;
      if (d_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h expected %h", a, d_out, 32'h0);
      end
    end
  endtask

  task automatic test_write_readback();
    do_write(4'h3, 32'hDEAD_BEEF);
    do_read(4'h3);
    n_checks++;
    if (d_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL readback_3: got %h expected %h", d_out, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_v;
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), {28'h0, 4'(a)} ^ 32'hA5A5_A5A5);
    end
    for (int a = 15; a >= 0; a--) begin
      exp_v = {28'h0, 4'(a)} ^ 32'hA5A5_A5A5;
      do_read(4'(a));
      n_checks++;
      if (d_out !== exp_v) begin
        n_fail++;
        $display("FAIL fill_read[%0d]: got %h expected %h", a, d_out, exp_v);
      end
    end
  endtask

  task automatic test_read_before_write();
    do_write(4'h7, 32'h1111_1111);
    addr = 4'h7; d_in = 32'h2222_2222; en_wr = 1'b1; en_rd = 1'b1;
    tick();
    en_wr = 1'b0; en_rd = 1'b0;
    n_checks++;
    if (d_out !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL rbw_old: got %h expected %h", d_out, 32'h1111_1111);
    end
    do_read(4'h7);
    n_checks++;
    if (d_out !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL rbw_new: got %h expected %h", d_out, 32'h2222_2222);
    end
  endtask

  task automatic test_hold();
    do_write(4'h2, 32'h1234_5678);
    do_read(4'h2);
    for (int i = 0; i < 5; i++) begin
      addr = 4'(i + 8); d_in = 32'h5555_0000 + 32'(i); en_wr = 1'b1; en_rd = 1'b0;
      tick();
      n_checks++;
      if (d_out !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h expected %h", i, d_out, 32'h1234_5678);
      end
    end
    en_wr = 1'b0;
    do_read(4'hA);
    n_checks++;
    if (d_out !== 32'h5555_0002) begin
      n_fail++;
      $display("FAIL hold_write_a: got %h expected %h", d_out, 32'h5555_0002);
    end
  endtask

  task automatic test_async_reset();
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), 32'hFFFF_FFFF);
    end
    do_read(4'h5);
    n_checks++;
    if (d_out !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL areset_pre: got %h expected %h", d_out, 32'hFFFF_FFFF);
    end
    addr = 4'h6; d_in = 32'h0BAD_0BAD; en_wr = 1'b1; en_rd = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h expected %h", d_out, 32'h0);
    end
    en_wr = 1'b0; en_rd = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      n_checks++;
      if (d_out !== 32'h0) begin
        n_fail++;
        $display("FAIL areset_read[%0d]: got %h expected %h", a, d_out, 32'h0);
      end
    end
  endtask

  task automatic test_write_disable();
    do_write(4'hF, 32'h0F0F_1234);
    addr = 4'hF; d_in = 32'hCAFE_F00D; en_wr = 1'b0; en_rd = 1'b0;
    repeat (2) tick();
    do_read(4'hF);
    n_checks++;
    if (d_out !== 32'h0F0F_1234) begin
      n_fail++;
      $display("FAIL wr_disable: got %h expected %h", d_out, 32'h0F0F_1234);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_readback();
    test_fill();
    test_read_before_write();
    test_hold();
    test_async_reset();
    test_write_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
